// File: rtl/sw_operand_feeder.sv
// Producer end of the CPU operand interface: synchronises and debounces the board
// switches and push-key, then presents one latched operand per physical key press.
module sw_operand_feeder #(
    parameter int n               = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] raw_sw,
    input  logic         raw_key,
    input  logic         ack,
    output logic [n-1:0] data_out,
    output logic         ready,
    output logic         busy,
    output logic         spurious_ack
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] C_DEB_LIMIT = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESENT  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0]        r_key_sync;
    logic [SYNC_STAGES-1:0][n-1:0] r_sw_sync;
    state_t                        r_state;
    logic [CW-1:0]                 r_cnt;
    logic [n-1:0]                  r_data;
    logic                          r_ready;
    logic                          r_busy;
    logic                          r_spurious;

    state_t                        w_state_nxt;
    logic [CW-1:0]                 w_cnt_nxt;
    logic [CW-1:0]                 w_cnt_inc;
    logic                          w_ready_nxt;
    logic                          w_load;
    logic                          w_key_s;
    logic [n-1:0]                  w_sw_s;

    assign w_key_s   = r_key_sync[SYNC_STAGES-1];
    assign w_sw_s    = r_sw_sync[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + CW'(1);

    // Input synchronisers for the key and every switch bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_sync <= {SYNC_STAGES{1'b0}};
            r_sw_sync  <= {(SYNC_STAGES*n){1'b0}};
        end else begin
            r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], raw_key};
            r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], raw_sw};
        end
    end

    // Next-state logic; w_cnt_inc is the number of stable samples including this one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = r_ready;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = CW'(0);
                if (w_key_s) begin
                    if (C_DEB_LIMIT == CW'(1)) begin
                        w_state_nxt = PRESENT;
                        w_ready_nxt = 1'b1;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = DEBOUNCE;
                        w_cnt_nxt   = CW'(1);
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DEBOUNCE: begin
                if (!w_key_s) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = CW'(0);
                end else if (w_cnt_inc == C_DEB_LIMIT) begin
                    w_state_nxt = PRESENT;
                    w_cnt_nxt   = CW'(0);
                    w_ready_nxt = 1'b1;
                    w_load      = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            PRESENT: begin
                w_ready_nxt = 1'b1;
                if (ack) begin
                    w_state_nxt = RELEASE;
                    w_ready_nxt = 1'b0;
                    w_cnt_nxt   = CW'(0);
                end else begin
                    w_state_nxt = PRESENT;
                end
            end
            RELEASE: begin
                // A re-press restarts the release window so one press yields one operand.
                if (w_key_s) begin
                    w_cnt_nxt   = CW'(0);
                end else if (w_cnt_inc == C_DEB_LIMIT) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = CW'(0);
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = CW'(0);
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= CW'(0);
            r_data     <= {n{1'b0}};
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_spurious <= r_spurious | (ack & ~r_ready);
            if (w_load) begin
                r_data <= w_sw_s;
            end else begin
                r_data <= r_data;
            end
        end
    end

    assign data_out     = r_data;
    assign ready        = r_ready;
    assign busy         = r_busy;
    assign spurious_ack = r_spurious;

endmodule

// File: tb/tb_sw_operand_feeder.sv
// Directed bench for sw_operand_feeder: expected operands are queued at each press
// and compared by a monitor whenever ready rises.
module tb_sw_operand_feeder;

    logic       clk;
    logic       reset;
    logic [7:0] raw_sw;
    logic       raw_key;
    logic       ack;
    logic [7:0] data_out;
    logic       ready;
    logic       busy;
    logic       spurious_ack;

    int         n_tests;
    int         n_fail;
    int         n_rise;
    logic       prev_ready;
    logic [7:0] exp_q[$];

    sw_operand_feeder #(.n(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_sw       (raw_sw),
        .raw_key      (raw_key),
        .ack          (ack),
        .data_out     (data_out),
        .ready        (ready),
        .busy         (busy),
        .spurious_ack (spurious_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ready) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    // Scoreboard monitor: every rising ready must present the oldest queued operand.
    always @(posedge clk) begin
        #1;
        if (ready === 1'b1 && prev_ready !== 1'b1) begin
            n_rise++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 32'd1);
            end else begin
                check("sb_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_ready = ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int highs;
        n_tests    = 0;
        n_fail     = 0;
        n_rise     = 0;
        prev_ready = 1'b0;
        reset      = 1'b0;
        raw_sw     = 8'h00;
        raw_key    = 1'b0;
        ack        = 1'b0;
        repeat (3) tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_spur", {31'd0, spurious_ack}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();

        // Bounce: key high for 3 cycles only.
        @(negedge clk);
        raw_key = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        raw_key = 1'b0;
        highs = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (ready) highs++;
        end
        check("bounce_busy_mid", {31'd0, busy}, 32'd1);
        tick();
        check("bounce_busy_idle", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ready) highs++;
        end
        check("bounce_no_ready", highs, 32'd0);
        check("bounce_data", {24'd0, data_out}, 32'h00);

        // Latency: A5 with key held.
        @(negedge clk);
        raw_sw  = 8'hA5;
        raw_key = 1'b1;
        exp_q.push_back(8'hA5);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("lat_busy_c%0d", k), {31'd0, busy}, (k >= 3) ? 32'd1 : 32'd0);
            check($sformatf("lat_ready_c%0d", k), {31'd0, ready}, (k >= 6) ? 32'd1 : 32'd0);
        end
        check("lat_data", {24'd0, data_out}, 32'hA5);

        // Switch changes are ignored while presenting; ack consumes.
        @(negedge clk);
        raw_sw = 8'h3C;
        repeat (3) tick();
        check("present_frozen", {24'd0, data_out}, 32'hA5);
        check("present_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        ack = 1'b1;
        tick();
        check("ack_ready_low", {31'd0, ready}, 32'd0);
        check("ack_data_hold", {24'd0, data_out}, 32'hA5);
        @(negedge clk);
        ack = 1'b0;
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ready) highs++;
        end
        check("held_key_no_retrigger", highs, 32'd0);
        check("held_key_busy", {31'd0, busy}, 32'd1);
        check("no_spur_yet", {31'd0, spurious_ack}, 32'd0);

        // Release must be stable for 4 synced samples before IDLE.
        @(negedge clk);
        raw_key = 1'b0;
        repeat (5) tick();
        check("release_busy_c5", {31'd0, busy}, 32'd1);
        tick();
        check("release_busy_c6", {31'd0, busy}, 32'd0);

        // Spurious ack in IDLE.
        @(negedge clk);
        ack = 1'b1;
        tick();
        check("spur_set", {31'd0, spurious_ack}, 32'd1);
        check("spur_ready", {31'd0, ready}, 32'd0);
        check("spur_busy", {31'd0, busy}, 32'd0);
        check("spur_data", {24'd0, data_out}, 32'hA5);
        @(negedge clk);
        ack = 1'b0;
        repeat (5) tick();
        check("spur_sticky", {31'd0, spurious_ack}, 32'd1);

        // Two full press/ack/release cycles, ack in the first ready cycle.
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            raw_sw  = (p == 0) ? 8'h01 : 8'hFF;
            raw_key = 1'b1;
            exp_q.push_back(raw_sw);
            wait_ready($sformatf("cycle%0d_ready", p));
            ack = 1'b1;
            tick();
            check($sformatf("cycle%0d_consumed", p), {31'd0, ready}, 32'd0);
            ack = 1'b0;
            @(negedge clk);
            raw_key = 1'b0;
            repeat (6) tick();
            check($sformatf("cycle%0d_idle", p), {31'd0, busy}, 32'd0);
        end
        check("last_data", {24'd0, data_out}, 32'hFF);
        check("rise_count_3", n_rise, 32'd3);

        // Asynchronous reset in the middle of PRESENT.
        @(negedge clk);
        raw_sw  = 8'h5A;
        raw_key = 1'b1;
        exp_q.push_back(8'h5A);
        wait_ready("mid_present_ready");
        #3;
        reset = 1'b0;
        #1;
        check("async_ready", {31'd0, ready}, 32'd0);
        check("async_data", {24'd0, data_out}, 32'h00);
        check("async_spur", {31'd0, spurious_ack}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        raw_key = 1'b0;
        reset   = 1'b1;
        repeat (3) tick();
        check("post_rst_ready", {31'd0, ready}, 32'd0);
        check("rise_count_4", n_rise, 32'd4);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
